multdiv_sequencer: RTL and testbench
====================================

Name: multdiv_sequencer

Overview:
- Multi-cycle sequencer for the processor's mult/div unit.
- Decodes R-type mul/div from the instruction fields and issues a one-cycle start pulse to the mult/div unit.
- Holds the PC/pipeline stalled until the unit reports a result or a timeout fires, then drives exactly one register-file writeback.
- Sits beside the main instruction decoder. Its writeback port is muxed into the regfile write path while `wb_en` is high.

Parameters:
- TIMEOUT_CYCLES, 40: max BUSY cycles before forced abort; counter width is clog2(TIMEOUT_CYCLES)+1.
- RSTATUS_REG, 30: register index written on exception.
- MUL_EXC_CODE, 4: value written to RSTATUS_REG on mul overflow or mul timeout.
- DIV_EXC_CODE, 5: value written to RSTATUS_REG on divide-by-zero or div timeout.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- opcode  in  5  instruction[31:27].
- aluOp  in  5  instruction[6:2].
- rd  in  5  destination register, instruction[26:22].
- md_result  in  32  mult/div unit result.
- md_exception  in  1  mult/div unit exception, valid with md_ready.
- md_ready  in  1  mult/div unit result-ready pulse.
- ctrl_MULT  out  1  one-cycle mul start pulse.
- ctrl_DIV  out  1  one-cycle div start pulse.
- stall  out  1  high freezes PC and blocks the main regfile write.
- wb_en  out  1  regfile write enable from this block.
- wb_reg  out  5  regfile write address.
- wb_data  out  32  regfile write data.
- busy  out  1  high in BUSY state.

Behaviour:
- Decode:
  - is_mul = (opcode==00000) & (aluOp==00110).
  - is_div = (opcode==00000) & (aluOp==00111).
  - start = (is_mul | is_div) & state==IDLE.
- FSM states: IDLE, BUSY, DONE. Reset forces IDLE.
- Reset values: all outputs 0, counter 0, latched op/rd/result/exception cleared.
- IDLE:
  - ctrl_MULT = is_mul & IDLE, ctrl_DIV = is_div & IDLE (combinational, asserted the same cycle the instruction is presented).
  - stall = start.
  - On start: latch op type and rd, clear counter, go to BUSY.
  - md_ready is ignored in IDLE.
- BUSY:
  - stall=1, busy=1, ctrl_* = 0, counter increments every cycle.
  - On md_ready=1: latch md_result and md_exception, go to DONE.
  - Else, when the counter reaches TIMEOUT_CYCLES-1: set the latched exception, go to DONE.
  - md_ready and timeout in the same cycle: md_ready wins, and its exception flag is used.
- DONE:
  - Lasts exactly one cycle. stall=0, so the PC advances at the end of this cycle. Then return to IDLE.
  - No decode occurs in DONE, so the held instruction does not re-trigger.
- Writeback in DONE:
  - If the latched exception is set: wb_en=1, wb_reg=RSTATUS_REG, wb_data = MUL_EXC_CODE or DIV_EXC_CODE (zero-extended to 32 bits), selected by the latched op.
  - Else if latched rd != 0: wb_en=1, wb_reg=rd, wb_data=latched result.
  - Else (rd==0): wb_en=0.
- Outside DONE: wb_en=0, and wb_reg/wb_data hold their last values.
- Latency: decode cycle is T0. If md_ready arrives in BUSY cycle T0+k (k≥1), the writeback and PC release happen in cycle T0+k+1.
- A second mul/div presented right after DONE starts a fresh sequence with no idle gap needed.
- Reset mid-BUSY or mid-DONE:
  - Immediate return to IDLE with outputs cleared; no writeback.
  - A later md_ready from the aborted operation is ignored, because the block is in IDLE.

Test Plan:
- mul, rd=5; md_ready 16 cycles after start with result 0x0000002A, exception=0 → ctrl_MULT high for one cycle at T0; stall high for 17 cycles; one cycle with wb_en=1, wb_reg=5, wb_data=0x2A.
- div, rd=7; md_ready after 32 cycles with md_exception=1 → ctrl_DIV pulse; writeback wb_reg=30, wb_data=5; no write to r7.
- mul, md_ready never asserted → after TIMEOUT_CYCLES=40 BUSY cycles, DONE writes r30=4; stall releases exactly once.
- mul with rd=0 and no exception → sequence completes with stall released and wb_en never asserted.
- Reset asserted mid-BUSY, then md_ready pulsed → all outputs 0, state IDLE, wb_en stays 0.
- Back-to-back: mul (rd=3) followed by div (rd=4); md_ready fires on the last BUSY-count cycle together with timeout → md_ready wins for each; two writebacks with correct data; exactly one ctrl pulse per instruction.

Source files
------------

// File: rtl/multdiv_sequencer.sv
// -----------------------------------------------------------------------------
// multdiv_sequencer
//
// Multi-cycle sequencer for the processor's mult/div unit. Decodes R-type
// mul/div from the instruction fields, fires a one-cycle start pulse at the
// unit, then holds the pipeline stalled until the unit reports a result or a
// timeout fires. The following cycle (DONE) drives exactly one register-file
// writeback: the result to rd, or an exception code to the status register.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   asynchronous, active-high reset
//   opcode       in   instruction[31:27]
//   aluOp        in   instruction[6:2]
//   rd           in   destination register, instruction[26:22]
//   md_result    in   mult/div unit result
//   md_exception in   mult/div unit exception, valid with md_ready
//   md_ready     in   mult/div unit result-ready pulse
//   ctrl_MULT    out  one-cycle mul start pulse (combinational, IDLE only)
//   ctrl_DIV     out  one-cycle div start pulse (combinational, IDLE only)
//   stall        out  freezes PC and blocks the main regfile write
//   wb_en        out  regfile write enable from this block (DONE only)
//   wb_reg       out  regfile write address (holds last value outside DONE)
//   wb_data      out  regfile write data (holds last value outside DONE)
//   busy         out  high while waiting on the mult/div unit
// -----------------------------------------------------------------------------
module multdiv_sequencer #(
    parameter int TIMEOUT_CYCLES = 40,
    parameter int RSTATUS_REG    = 30,
    parameter int MUL_EXC_CODE   = 4,
    parameter int DIV_EXC_CODE   = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  opcode,
    input  logic [4:0]  aluOp,
    input  logic [4:0]  rd,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_ready,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic        stall,
    output logic        wb_en,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic        busy
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] busy_cnt;
    logic             op_div_q;   // latched op type: 1 = div, 0 = mul
    logic [4:0]       rd_q;       // latched destination register

    logic is_rtype;
    logic is_mul;
    logic is_div;
    logic start;
    logic timeout;
    logic exc_next;

    assign is_rtype = (opcode == 5'b00000);
    assign is_mul   = is_rtype && (aluOp == 5'b00110);
    assign is_div   = is_rtype && (aluOp == 5'b00111);

    // Decode only in IDLE: the instruction is still held on the bus during
    // DONE and must not retrigger.
    assign start     = (is_mul || is_div) && (state == IDLE);
    assign ctrl_MULT = is_mul && (state == IDLE);
    assign ctrl_DIV  = is_div && (state == IDLE);

    // Stall is raised in the decode cycle itself so the PC never advances
    // past the mul/div; it drops in DONE so the PC moves on at its end.
    assign stall = start || (state == BUSY);
    assign busy  = (state == BUSY);

    assign timeout = (busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // A real md_ready always wins over a coincident timeout; a bare timeout
    // is reported as an exception.
    assign exc_next = md_ready ? md_exception : 1'b1;

    // NOTE: asynchronous reset; every register here is a small control or
    // datapath register, so all of them are cleared and no reset-less storage
    // is involved.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            busy_cnt <= '0;
            op_div_q <= 1'b0;
            rd_q     <= 5'd0;
            wb_en    <= 1'b0;
            wb_reg   <= 5'd0;
            wb_data  <= 32'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            unique case (state)
                IDLE: begin
                    wb_en <= 1'b0;
                    if (start) begin
                        op_div_q <= is_div;
                        rd_q     <= rd;
                        busy_cnt <= '0;
                        state    <= BUSY;
                    end
                end

                BUSY: begin
                    busy_cnt <= busy_cnt + CNT_W'(1);
                    if (md_ready || timeout) begin
                        state <= DONE;
                        // The writeback registers double as the latched
                        // result/exception, so the DONE-cycle write comes
                        // straight from flops.
                        if (exc_next) begin
                            wb_en   <= 1'b1;
                            wb_reg  <= 5'(RSTATUS_REG);
                            wb_data <= op_div_q ? 32'(DIV_EXC_CODE)
                                                : 32'(MUL_EXC_CODE);
                        end else if (rd_q != 5'd0) begin
                            wb_en   <= 1'b1;
                            wb_reg  <= rd_q;
                            wb_data <= md_result;
                        end
                    end
                end

                DONE: begin
                    wb_en <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    wb_en <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_sequencer.sv
module tb_multdiv_sequencer;

    localparam int TIMEOUT = 40;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  opcode;
    logic [4:0]  aluOp;
    logic [4:0]  rd;
    logic [31:0] md_result;
    logic        md_exception;
    logic        md_ready;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic        stall;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    multdiv_sequencer #(
        .TIMEOUT_CYCLES(TIMEOUT),
        .RSTATUS_REG   (30),
        .MUL_EXC_CODE  (4),
        .DIV_EXC_CODE  (5)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .opcode      (opcode),
        .aluOp       (aluOp),
        .rd          (rd),
        .md_result   (md_result),
        .md_exception(md_exception),
        .md_ready    (md_ready),
        .ctrl_MULT   (ctrl_MULT),
        .ctrl_DIV    (ctrl_DIV),
        .stall       (stall),
        .wb_en       (wb_en),
        .wb_reg      (wb_reg),
        .wb_data     (wb_data),
        .busy        (busy)
    );

    // Drive an add (opcode 0, aluOp 0): an R-type that is neither mul nor div.
    task automatic set_nop;
        opcode = 5'b00000;
        aluOp  = 5'b00000;
        rd     = 5'd1;
    endtask

    task automatic test_reset;
        reset        = 1'b1;
        set_nop();
        md_ready     = 1'b0;
        md_exception = 1'b0;
        md_result    = 32'd0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if ({ctrl_MULT, ctrl_DIV, stall, wb_en, busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {ctrl_MULT, ctrl_DIV, stall, wb_en, busy});
        end
        checks++;
        if ({wb_reg, wb_data} !== 37'd0) begin
            errors++;
            $display("FAIL reset_wb: got reg=%0d data=%0h expected 0/0", wb_reg, wb_data);
        end
        reset = 1'b0;
        @(posedge clock);
        #1;
        checks++;
        if ({stall, wb_en, busy} !== 3'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got %b expected 000", {stall, wb_en, busy});
        end
    endtask

    // Present one mul/div (held on the bus until after DONE) and follow it
    // cycle by cycle. ready_at = BUSY cycle index (T0 = 0) carrying md_ready,
    // or 0 for never. Returns one clock after DONE, at posedge + 1.
    task automatic run_op(input string name, input logic is_div_op,
                          input logic [4:0] dst, input int ready_at,
                          input logic [31:0] res, input logic exc,
                          input logic exp_en, input logic [4:0] exp_reg,
                          input logic [31:0] exp_data);
        int   mul_p = 0;
        int   div_p = 0;
        int   stall_n = 0;
        int   busy_n = 0;
        int   wb_n = 0;
        logic done = 1'b0;
        int   exp_stall;
        exp_stall = (ready_at > 0) ? ready_at + 1 : TIMEOUT + 1;

        checks++;
        if (wb_en !== 1'b0) begin
            errors++;
            $display("FAIL %s wb_en_at_T0: got %b expected 0", name, wb_en);
        end

        opcode = 5'b00000;
        aluOp  = is_div_op ? 5'b00111 : 5'b00110;
        rd     = dst;
        for (int c = 0; c < 80 && !done; c++) begin
            md_ready     = (ready_at > 0) && (c == ready_at);
            md_result    = md_ready ? res : 32'hDEAD_BEEF;
            md_exception = md_ready ? exc : 1'b1;  // noise while not ready
            #1;
            if (ctrl_MULT === 1'b1) mul_p++;
            if (ctrl_DIV === 1'b1)  div_p++;
            if (stall === 1'b1)     stall_n++;
            if (busy === 1'b1)      busy_n++;
            if (wb_en === 1'b1)     wb_n++;
            if (c > 0 && stall === 1'b0) begin
                done = 1'b1;
                checks++;
                if (wb_en !== exp_en) begin
                    errors++;
                    $display("FAIL %s done_wb_en: got %b expected %b", name, wb_en, exp_en);
                end
                if (exp_en) begin
                    checks++;
                    if (wb_reg !== exp_reg || wb_data !== exp_data) begin
                        errors++;
                        $display("FAIL %s wb: got reg=%0d data=%0h expected reg=%0d data=%0h",
                                 name, wb_reg, wb_data, exp_reg, exp_data);
                    end
                end
            end
            @(posedge clock);
            #1;
        end
        md_ready     = 1'b0;
        md_exception = 1'b0;

        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s done_reached: got 0 expected 1", name);
        end
        checks++;
        if (mul_p != (is_div_op ? 0 : 1) || div_p != (is_div_op ? 1 : 0)) begin
            errors++;
            $display("FAIL %s ctrl_pulses: got mul=%0d div=%0d expected mul=%0d div=%0d",
                     name, mul_p, div_p, is_div_op ? 0 : 1, is_div_op ? 1 : 0);
        end
        checks++;
        if (stall_n != exp_stall) begin
            errors++;
            $display("FAIL %s stall_cycles: got %0d expected %0d", name, stall_n, exp_stall);
        end
        checks++;
        if (busy_n != exp_stall - 1) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_n, exp_stall - 1);
        end
        checks++;
        if (wb_n != (exp_en ? 1 : 0)) begin
            errors++;
            $display("FAIL %s wb_count: got %0d expected %0d", name, wb_n, exp_en ? 1 : 0);
        end
    endtask

    // Drop the instruction and confirm the block sits quietly in IDLE.
    task automatic check_idle(input string name);
        set_nop();
        #1;
        checks++;
        if ({stall, busy, wb_en, ctrl_MULT, ctrl_DIV} !== 5'b0) begin
            errors++;
            $display("FAIL %s idle: got %b expected 00000", name,
                     {stall, busy, wb_en, ctrl_MULT, ctrl_DIV});
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_mul_basic;
        run_op("mul_rd5", 1'b0, 5'd5, 16, 32'h0000_002A, 1'b0, 1'b1, 5'd5, 32'h0000_002A);
        check_idle("mul_rd5");
    endtask

    task automatic test_div_exception;
        run_op("div_exc", 1'b1, 5'd7, 32, 32'h0000_1234, 1'b1, 1'b1, 5'd30, 32'd5);
        check_idle("div_exc");
    endtask

    task automatic test_mul_timeout;
        run_op("mul_timeout", 1'b0, 5'd6, 0, 32'd0, 1'b0, 1'b1, 5'd30, 32'd4);
        check_idle("mul_timeout");
    endtask

    task automatic test_rd_zero;
        run_op("mul_rd0", 1'b0, 5'd0, 5, 32'h0000_0099, 1'b0, 1'b0, 5'd0, 32'd0);
        check_idle("mul_rd0");
    endtask

    task automatic test_reset_mid_busy;
        opcode = 5'b00000;
        aluOp  = 5'b00110;
        rd     = 5'd9;
        repeat (4) @(posedge clock);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid busy_before: got %b expected 1", busy);
        end
        reset = 1'b1;
        set_nop();
        #1;
        checks++;
        if ({ctrl_MULT, ctrl_DIV, stall, wb_en, busy, wb_reg, wb_data} !== 42'd0) begin
            errors++;
            $display("FAIL rst_mid outputs: got stall=%b busy=%b wb_en=%b reg=%0d data=%0h expected all 0",
                     stall, busy, wb_en, wb_reg, wb_data);
        end
        @(posedge clock);
        #1;
        reset        = 1'b0;
        md_ready     = 1'b1;
        md_exception = 1'b1;
        md_result    = 32'h0000_0055;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if ({stall, busy, wb_en} !== 3'b0) begin
                errors++;
                $display("FAIL rst_mid stale_ready c%0d: got %b expected 000", c,
                         {stall, busy, wb_en});
            end
            @(posedge clock);
            #1;
            md_ready     = 1'b0;
            md_exception = 1'b0;
        end
    endtask

    task automatic test_back_to_back;
        run_op("b2b_mul", 1'b0, 5'd3, TIMEOUT, 32'h0000_1111, 1'b0, 1'b1, 5'd3, 32'h0000_1111);
        run_op("b2b_div", 1'b1, 5'd4, TIMEOUT, 32'h0000_2222, 1'b0, 1'b1, 5'd4, 32'h0000_2222);
        check_idle("b2b");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_mul_basic();
        test_div_exception();
        test_mul_timeout();
        test_rd_zero();
        test_reset_mid_busy();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
